// File: rtl/jt89_wr_arb_if.sv
// Write-port bundle for the two JT89 CPU requesters (A = 68k side, B = Z80 side).
// The CPU side uses the master modport and the arbiter uses the slave modport.
interface jt89_wr_arb_if;
  logic       a_wr;
  logic [7:0] a_din;
  logic       a_busy;
  logic       a_ovf;
  logic       b_wr;
  logic [7:0] b_din;
  logic       b_busy;
  logic       b_ovf;

  modport master (output a_wr, a_din, b_wr, b_din,
                  input  a_busy, a_ovf, b_busy, b_ovf);
  modport slave  (input  a_wr, a_din, b_wr, b_din,
                  output a_busy, a_ovf, b_busy, b_ovf);
endinterface

// File: rtl/jt89_wr_arb.sv
// JT89 write arbiter: serialises SN76489-format bytes from two requesters
// round-robin and decodes them into the tone, volume and noise registers.
module jt89_wr_arb (
  input  logic                clk,
  input  logic                rst,
  jt89_wr_arb_if.slave        bus,
  output logic [9:0]          tone0,
  output logic [9:0]          tone1,
  output logic [9:0]          tone2,
  output logic [3:0]          vol0,
  output logic [3:0]          vol1,
  output logic [3:0]          vol2,
  output logic [3:0]          vol3,
  output logic [2:0]          ctrl3,
  output logic                clr
);

  logic       pend_a, pend_b;
  logic [7:0] hold_a, hold_b;
  logic [1:0] ch_a, ch_b;
  logic       typ_a, typ_b;
  logic       rr_b;    // B gets the next contended grant
  logic       a_ovf_q, b_ovf_q;

  logic       gnt_a, gnt_b, gnt_any;
  logic [7:0] d;
  logic       latch;
  logic [1:0] eff_ch;
  logic       eff_typ;

  assign bus.a_busy = pend_a;
  assign bus.b_busy = pend_b;
  assign bus.a_ovf  = a_ovf_q;
  assign bus.b_ovf  = b_ovf_q;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_a   = pend_a & (~pend_b | ~rr_b);
    gnt_b   = pend_b & ~gnt_a;
    gnt_any = gnt_a | gnt_b;
    d       = gnt_a ? hold_a : hold_b;
    latch   = d[7];
    eff_ch  = gnt_a ? ch_a  : ch_b;
    eff_typ = gnt_a ? typ_a : typ_b;
    if (latch) begin
      eff_ch  = d[6:5];
      eff_typ = d[4];
    end
  end

  // NOTE: hold_a/hold_b are not reset; their contents only matter while pend is set.
  always_ff @(posedge clk) begin
    if (bus.a_wr && !pend_a) hold_a <= bus.a_din;
    if (bus.b_wr && !pend_b) hold_b <= bus.b_din;
  end

  // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_a  <= 1'b0;
      pend_b  <= 1'b0;
      a_ovf_q <= 1'b0;
      b_ovf_q <= 1'b0;
      ch_a    <= 2'd0;
      ch_b    <= 2'd0;
      typ_a   <= 1'b0;
      typ_b   <= 1'b0;
      rr_b    <= 1'b0;
      tone0   <= 10'd0;
      tone1   <= 10'd0;
      tone2   <= 10'd0;
      vol0    <= 4'hF;
      vol1    <= 4'hF;
      vol2    <= 4'hF;
      vol3    <= 4'hF;
      ctrl3   <= 3'd0;
      clr     <= 1'b0;
    end else begin
      clr <= 1'b0;

      // A strobe while the holding register is full is dropped and flagged.
      pend_a <= (pend_a & ~gnt_a) | (bus.a_wr & ~pend_a);
      pend_b <= (pend_b & ~gnt_b) | (bus.b_wr & ~pend_b);
      if (bus.a_wr && pend_a) a_ovf_q <= 1'b1;
      if (bus.b_wr && pend_b) b_ovf_q <= 1'b1;

      // The pointer only moves on contention, so the loser of one collision wins the next.
      if (pend_a && pend_b) rr_b <= gnt_a;

      if (gnt_any && latch) begin
        if (gnt_a) begin
          ch_a  <= eff_ch;
          typ_a <= eff_typ;
        end else begin
          ch_b  <= eff_ch;
          typ_b <= eff_typ;
        end
      end

      if (gnt_any) begin
        if (eff_typ) begin
          case (eff_ch)
            2'd0:    vol0 <= d[3:0];
            2'd1:    vol1 <= d[3:0];
            2'd2:    vol2 <= d[3:0];
            default: vol3 <= d[3:0];
          endcase
        end else if (eff_ch == 2'd3) begin
          ctrl3 <= d[2:0];
          clr   <= 1'b1;
        end else if (latch) begin
          case (eff_ch)
            2'd0:    tone0[3:0] <= d[3:0];
            2'd1:    tone1[3:0] <= d[3:0];
            default: tone2[3:0] <= d[3:0];
          endcase
        end else begin
          case (eff_ch)
            2'd0:    tone0[9:4] <= d[5:0];
            2'd1:    tone1[9:4] <= d[5:0];
            default: tone2[9:4] <= d[5:0];
          endcase
        end
      end
    end
  end

endmodule
